keypad_lock: RTL

KEYPAD_LOCK -- requirements
Module: keypad_lock

---
 rtl/keypad_pkg.sv | 66 ++++++
 rtl/tone_gen.sv | 88 ++++++++
 rtl/keypad_lock.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad lock: key codes, display glyphs,
// state and tone encodings, and the raw-key decoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_SET     = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TONE_CLICK   = 2'd0,
    TONE_SUCCESS = 2'd1,
    TONE_FAIL    = 2'd2
  } tone_e;

  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_DIGIT,
    KEY_ENTER,
    KEY_SET,
    KEY_CLEAR,
    KEY_CLRTRIES
  } key_kind_e;

  typedef struct packed {
    key_kind_e  kind;
    logic [3:0] digit;
  } key_t;

  localparam logic [15:0] K_ENTER    = 16'h0001;
  localparam logic [15:0] K_SET      = 16'h0010;
  localparam logic [15:0] K_CLEAR    = 16'h1000;
  localparam logic [15:0] K_CLRTRIES = 16'h0100;

  localparam logic [3:0] GLYPH_BLANK   = 4'hF;
  localparam logic [3:0] GLYPH_SETFILL = 4'hD;
  localparam logic [3:0] GLYPH_PASS_HI = 4'hB;
  localparam logic [3:0] GLYPH_PASS_LO = 4'hC;

  function automatic key_t decode_key(input logic [15:0] oh);
    key_t k;
    k.kind  = KEY_NONE;
    k.digit = 4'd0;
    case (oh)
      16'h0008: begin k.kind = KEY_DIGIT; k.digit = 4'd0; end
      16'h0080: begin k.kind = KEY_DIGIT; k.digit = 4'd1; end
      16'h0040: begin k.kind = KEY_DIGIT; k.digit = 4'd2; end
      16'h0020: begin k.kind = KEY_DIGIT; k.digit = 4'd3; end
      16'h0800: begin k.kind = KEY_DIGIT; k.digit = 4'd4; end
      16'h0400: begin k.kind = KEY_DIGIT; k.digit = 4'd5; end
      16'h0200: begin k.kind = KEY_DIGIT; k.digit = 4'd6; end
      16'h8000: begin k.kind = KEY_DIGIT; k.digit = 4'd7; end
      16'h4000: begin k.kind = KEY_DIGIT; k.digit = 4'd8; end
      16'h2000: begin k.kind = KEY_DIGIT; k.digit = 4'd9; end
      K_ENTER:    k.kind = KEY_ENTER;
      K_SET:      k.kind = KEY_SET;
      K_CLEAR:    k.kind = KEY_CLEAR;
      K_CLRTRIES: k.kind = KEY_CLRTRIES;
      default:    k.kind = KEY_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Buzzer square-wave generator for click, success and fail tones.
// A start pulse always restarts the tone from the high phase.
module tone_gen
  import keypad_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic  clk,
  input  logic  RST,
  input  logic  start,
  input  tone_e kind,
  output logic  buzzer
);

  localparam int CLICK_HALF = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int SUCC_HALF  = (CLK_HZ / 2000 > 0) ? CLK_HZ / 2000 : 1;
  localparam int FAIL_HALF  = (CLK_HZ / 500 > 0) ? CLK_HZ / 500 : 1;
  localparam int CLICK_DUR  = CLK_HZ / 5;
  localparam int SUCC_DUR   = 3 * CLK_HZ / 5;
  localparam int FAIL_DUR   = 3 * CLK_HZ / 10;

  localparam int DW = $clog2(SUCC_DUR + 1);
  localparam int HW = $clog2(FAIL_HALF + 1);

  // Fail tone goes quiet between 1/10 s and 1/5 s of elapsed time,
  // expressed here as a window on the remaining-time counter.
  localparam logic [DW-1:0] SIL_HI = DW'(FAIL_DUR - 1 - CLK_HZ / 10);
  localparam logic [DW-1:0] SIL_LO = DW'(FAIL_DUR - 1 - CLK_HZ / 5);

  function automatic int half_of(input tone_e k);
    case (k)
      TONE_SUCCESS: return SUCC_HALF;
      TONE_FAIL:    return FAIL_HALF;
      default:      return CLICK_HALF;
    endcase
  endfunction

  function automatic int dur_of(input tone_e k);
    case (k)
      TONE_SUCCESS: return SUCC_DUR;
      TONE_FAIL:    return FAIL_DUR;
      default:      return CLICK_DUR;
    endcase
  endfunction

  logic          active;
  tone_e         kind_q;
  logic [HW-1:0] half_cnt;
  logic [DW-1:0] rem;
  logic          phase;
  logic [DW-1:0] rem_n;
  logic          phase_n;
  logic          silent_n;

  assign rem_n    = rem - DW'(1);
  assign phase_n  = (half_cnt == '0) ? ~phase : phase;
  assign silent_n = (kind_q == TONE_FAIL) && (rem_n <= SIL_HI) && (rem_n > SIL_LO);

  always_ff @(posedge clk) begin
    if (RST) begin
      active   <= 1'b0;
      kind_q   <= TONE_CLICK;
      half_cnt <= '0;
      rem      <= '0;
      phase    <= 1'b0;
      buzzer   <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      kind_q   <= kind;
      half_cnt <= HW'(half_of(kind) - 1);
      rem      <= DW'(dur_of(kind) - 1);
      phase    <= 1'b1;
      buzzer   <= 1'b1;
    end else if (active) begin
      if (rem == '0) begin
        active <= 1'b0;
        phase  <= 1'b0;
        buzzer <= 1'b0;
      end else begin
        rem      <= rem_n;
        half_cnt <= (half_cnt == '0) ? HW'(half_of(kind_q) - 1) : half_cnt - HW'(1);
        phase    <= phase_n;
        buzzer   <= phase_n & ~silent_n;
      end
    end
  end

endmodule

// File: rtl/keypad_lock.sv
// Keypad code lock: key-event detection, code entry/compare/change,
// failed-attempt lockout with a seconds countdown, and buzzer tones.
//
// state      | meaning
// ENTRY      | collecting digits of a candidate code
// SET        | collecting digits of a replacement code
// OPEN       | correct code accepted, PASS shown
// LOCKOUT    | keys ignored, remaining seconds shown
module keypad_lock
  import keypad_pkg::*;
#(
  parameter int                 DIGITS       = 3,
  parameter int                 MAX_TRIES    = 3,
  parameter int                 LOCK_SECS    = 20,
  parameter int                 CLK_HZ       = 50_000_000,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 12'h246
) (
  input  logic                clk,
  input  logic                RST,
  input  logic [15:0]         onehot,
  output logic [4*DIGITS-1:0] disp,
  output logic [3:0]          tries,
  output logic [1:0]          state,
  output logic                buzzer
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(CLK_HZ + 1);

  localparam logic [2:0]   CNT_FULL  = 3'(DIGITS);
  localparam logic [3:0]   TRY_LAST  = 4'(MAX_TRIES - 1);
  localparam logic [PW-1:0] PRE_LOAD = PW'(CLK_HZ - 1);
  localparam logic [W-1:0] BLANK_DISP = {DIGITS{GLYPH_BLANK}};
  localparam logic [W-1:0] SET_DISP   = {DIGITS{GLYPH_SETFILL}};

  function automatic logic [W-1:0] pass_glyph();
    logic [W-1:0] g;
    g = '0;
    for (int i = 0; i < DIGITS; i++)
      g[4*i +: 4] = (i < 2) ? GLYPH_PASS_LO : (i == 2) ? GLYPH_PASS_HI : GLYPH_BLANK;
    return g;
  endfunction

  localparam logic [W-1:0] PASS_DISP = pass_glyph();

  function automatic logic [W-1:0] lock_disp(input logic [6:0] s);
    logic [W-1:0] g;
    g      = BLANK_DISP;
    g[7:4] = 4'(s / 7'd10);
    g[3:0] = 4'(s % 7'd10);
    return g;
  endfunction

  logic [15:0] oh_q;
  logic        hold_q;
  logic        evt_q;
  key_t        key_q;
  logic        single_bit;

  assign single_bit = (onehot != '0) && ((onehot & (onehot - 16'd1)) == '0);

  // hold_q suppresses a key that was already down while reset was applied.
  always_ff @(posedge clk) begin
    if (RST) begin
      oh_q   <= '0;
      hold_q <= 1'b1;
      evt_q  <= 1'b0;
      key_q  <= '0;
    end else begin
      oh_q   <= onehot;
      hold_q <= hold_q && (onehot != '0);
      evt_q  <= !hold_q && (oh_q == '0) && single_bit;
      key_q  <= decode_key(onehot);
    end
  end

  state_e        st;
  logic [W-1:0]  code;
  logic [2:0]    cnt;
  logic [PW-1:0] pre;
  logic [6:0]    secs;
  logic          tone_start;
  tone_e         tone_kind;

  always_ff @(posedge clk) begin
    if (RST) begin
      st         <= ST_ENTRY;
      disp       <= BLANK_DISP;
      tries      <= '0;
      code       <= DEFAULT_CODE;
      cnt        <= '0;
      pre        <= '0;
      secs       <= '0;
      tone_start <= 1'b0;
      tone_kind  <= TONE_CLICK;
    end else begin
      tone_start <= 1'b0;
      if (st == ST_LOCKOUT) begin
        if (pre == '0) begin
          pre <= PRE_LOAD;
          if (secs == 7'd1) begin
            st   <= ST_ENTRY;
            disp <= BLANK_DISP;
            cnt  <= '0;
            secs <= '0;
          end else begin
            secs <= secs - 7'd1;
            disp <= lock_disp(secs - 7'd1);
          end
        end else begin
          pre <= pre - PW'(1);
        end
      end else if (evt_q) begin
        case (key_q.kind)
          KEY_DIGIT: begin
            if ((st == ST_ENTRY || st == ST_SET) && cnt < CNT_FULL) begin
              disp       <= {disp[W-5:0], key_q.digit};
              cnt        <= cnt + 3'd1;
              tone_start <= 1'b1;
              tone_kind  <= TONE_CLICK;
            end
          end
          KEY_ENTER: begin
            if ((st == ST_ENTRY || st == ST_SET) && cnt == CNT_FULL) begin
              cnt        <= '0;
              tone_start <= 1'b1;
              if (st == ST_SET) begin
                code      <= disp;
                st        <= ST_ENTRY;
                disp      <= BLANK_DISP;
                tone_kind <= TONE_SUCCESS;
              end else if (disp == code) begin
                st        <= ST_OPEN;
                disp      <= PASS_DISP;
                tries     <= '0;
                tone_kind <= TONE_SUCCESS;
              end else if (tries == TRY_LAST) begin
                st        <= ST_LOCKOUT;
                tries     <= '0;
                secs      <= 7'(LOCK_SECS);
                pre       <= PRE_LOAD;
                disp      <= lock_disp(7'(LOCK_SECS));
                tone_kind <= TONE_FAIL;
              end else begin
                tries     <= tries + 4'd1;
                disp      <= BLANK_DISP;
                tone_kind <= TONE_FAIL;
              end
            end
          end
          KEY_SET: begin
            if (st == ST_OPEN) begin
              st   <= ST_SET;
              disp <= SET_DISP;
              cnt  <= '0;
            end
          end
          KEY_CLEAR, KEY_CLRTRIES: begin
            st   <= ST_ENTRY;
            disp <= BLANK_DISP;
            cnt  <= '0;
            if (key_q.kind == KEY_CLRTRIES) tries <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign state = st;

  tone_gen #(.CLK_HZ(CLK_HZ)) u_tone (
    .clk    (clk),
    .RST    (RST),
    .start  (tone_start),
    .kind   (tone_kind),
    .buzzer (buzzer)
  );

endmodule
